// File: rtl/tm_pkg.sv
// tm_pkg: shared types and constants for the TM priority-scheduler PIO initiators
package tm_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
    localparam int NUM_PRI_BANKS = 8;
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/tm_sch_pri_pio_ctrl_if.sv
// tm_sch_pri_pio_ctrl_if: host-side single-request PIO handshake
interface tm_sch_pri_pio_ctrl_if #(parameter int PIO_NBITS = 32);
    logic                 host_req;
    logic                 host_wr;
    logic [PIO_NBITS-1:0] host_addr;
    logic [PIO_NBITS-1:0] host_wdata;
    logic                 host_busy;
    logic                 host_ack;
    logic                 host_err;
    logic [PIO_NBITS-1:0] host_rdata;
    modport master (output host_req, host_wr, host_addr, host_wdata,
                    input  host_busy, host_ack, host_err, host_rdata);
    modport slave  (input  host_req, host_wr, host_addr, host_wdata,
                    output host_busy, host_ack, host_err, host_rdata);
endinterface

// File: rtl/tm_pio_timeout_cnt.sv
// tm_pio_timeout_cnt: access watchdog; expire is high in the TIMEOUT-th enabled cycle after clear
module tm_pio_timeout_cnt #(
    parameter int NBITS   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expire
);
    logic [NBITS-1:0] cnt;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    assign expire = en && (cnt == NBITS'(TIMEOUT - 1));
endmodule

// File: rtl/tm_sch_pri_pio_ctrl.sv
// tm_sch_pri_pio_ctrl: PIO initiator for the eight priority-scheduler control memory banks
module tm_sch_pri_pio_ctrl
    import tm_pkg::*;
#(
    parameter int                   PIO_NBITS     = 32,
    parameter int                   DEPTH_NBITS   = 6,
    parameter logic [PIO_NBITS-1:0] BASE_ADDR     = 32'h0001_0000,
    parameter int                   TIMEOUT_NBITS = 8,
    parameter int                   TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     rstn,
    tm_sch_pri_pio_ctrl_if.slave     host,
    output logic [PIO_NBITS-1:0]     reg_addr,
    output logic [PIO_NBITS-1:0]     reg_din,
    output logic                     reg_rd,
    output logic                     reg_wr,
    output logic [NUM_PRI_BANKS-1:0] reg_ms_pri_sch_ctrl,
    input  logic [NUM_PRI_BANKS-1:0] pri_sch_ctrl_mem_ack,
    input  logic [PIO_NBITS-1:0]     pri_sch_ctrl_mem_rdata0,
    input  logic [PIO_NBITS-1:0]     pri_sch_ctrl_mem_rdata1,
    input  logic [PIO_NBITS-1:0]     pri_sch_ctrl_mem_rdata2,
    input  logic [PIO_NBITS-1:0]     pri_sch_ctrl_mem_rdata3,
    input  logic [PIO_NBITS-1:0]     pri_sch_ctrl_mem_rdata4,
    input  logic [PIO_NBITS-1:0]     pri_sch_ctrl_mem_rdata5,
    input  logic [PIO_NBITS-1:0]     pri_sch_ctrl_mem_rdata6,
    input  logic [PIO_NBITS-1:0]     pri_sch_ctrl_mem_rdata7
);
    state_e               state;
    logic [2:0]           bank;
    logic [2:0]           bank_q;
    logic                 hit;
    logic                 expire;
    logic [PIO_NBITS-1:0] mem_rdata [NUM_PRI_BANKS];

    assign mem_rdata[0] = pri_sch_ctrl_mem_rdata0;
    assign mem_rdata[1] = pri_sch_ctrl_mem_rdata1;
    assign mem_rdata[2] = pri_sch_ctrl_mem_rdata2;
    assign mem_rdata[3] = pri_sch_ctrl_mem_rdata3;
    assign mem_rdata[4] = pri_sch_ctrl_mem_rdata4;
    assign mem_rdata[5] = pri_sch_ctrl_mem_rdata5;
    assign mem_rdata[6] = pri_sch_ctrl_mem_rdata6;
    assign mem_rdata[7] = pri_sch_ctrl_mem_rdata7;

    assign bank           = host.host_addr[DEPTH_NBITS+4:DEPTH_NBITS+2];
    assign hit            = host.host_addr[PIO_NBITS-1:DEPTH_NBITS+5] == BASE_ADDR[PIO_NBITS-1:DEPTH_NBITS+5];
    assign host.host_busy = state != IDLE;

    tm_pio_timeout_cnt #(.NBITS(TIMEOUT_NBITS), .TIMEOUT(TIMEOUT)) u_tmo (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (state != ACCESS),
        .en     (state == ACCESS),
        .expire (expire)
    );

    // Bus signals change only on entry/exit of ACCESS so slow clk_div banks see a stable request
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state               <= IDLE;
            bank_q              <= '0;
            reg_addr            <= '0;
            reg_din             <= '0;
            reg_rd              <= 1'b0;
            reg_wr              <= 1'b0;
            reg_ms_pri_sch_ctrl <= '0;
            host.host_ack       <= 1'b0;
            host.host_err       <= 1'b0;
            host.host_rdata     <= '0;
        end else begin
            case (state)
                IDLE: if (host.host_req) begin
                    if (hit) begin
                        state               <= ACCESS;
                        bank_q              <= bank;
                        reg_addr            <= host.host_addr;
                        reg_din             <= host.host_wdata;
                        reg_rd              <= !host.host_wr;
                        reg_wr              <= host.host_wr;
                        reg_ms_pri_sch_ctrl <= NUM_PRI_BANKS'(1) << bank;
                    end else begin
                        state         <= RESP;
                        host.host_ack <= 1'b1;
                        host.host_err <= 1'b1;
                    end
                end
                ACCESS: if (pri_sch_ctrl_mem_ack[bank_q] || expire) begin
                    state               <= RESP;
                    reg_rd              <= 1'b0;
                    reg_wr              <= 1'b0;
                    reg_ms_pri_sch_ctrl <= '0;
                    host.host_ack       <= 1'b1;
                    host.host_err       <= !pri_sch_ctrl_mem_ack[bank_q];
                    host.host_rdata     <= pri_sch_ctrl_mem_ack[bank_q] ? (reg_rd ? mem_rdata[bank_q] : '0)
                                                                        : PIO_NBITS'(TIMEOUT_RDATA);
                end
                default: begin
                    state         <= IDLE;
                    host.host_ack <= 1'b0;
                    host.host_err <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/tm_sch_pri_pio_ctrl.md
Name: tm_sch_pri_pio_ctrl

Overview:
PIO-side initiator for the eight priority-scheduler control memory banks. It takes single host register requests, decodes the bank and entry, and drives the shared reg_* bus plus a one-hot bank select. It holds the access until the selected bank acks or a timeout fires, then returns read data and status to the host. It sits between the TM register block and the priority-scheduler control memory bank array.

Parameters:
PIO_NBITS, 32, width of the PIO address and data.
DEPTH_NBITS, 6, entry-index bits per bank (third-level scheduler ID width).
BASE_ADDR, 32'h0001_0000, region base; compared on bits [PIO_NBITS-1:DEPTH_NBITS+5].
TIMEOUT_NBITS, 8, timeout counter width.
TIMEOUT, 255, cycles in ACCESS before abort (1..2^TIMEOUT_NBITS-1).

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
host_req  in  1  single-cycle request strobe
host_wr  in  1  1=write, 0=read; sampled with host_req
host_addr  in  PIO_NBITS  byte address; sampled with host_req
host_wdata  in  PIO_NBITS  write data; sampled with host_req
host_busy  out  1  request in flight; host_req is ignored while high
host_ack  out  1  one-cycle completion pulse
host_err  out  1  valid with host_ack: decode miss or timeout
host_rdata  out  PIO_NBITS  read data, valid with host_ack
reg_addr  out  PIO_NBITS  latched address to the banks
reg_din  out  PIO_NBITS  latched write data to the banks
reg_rd  out  1  read strobe, level
reg_wr  out  1  write strobe, level
reg_ms_pri_sch_ctrl  out  8  one-hot bank select
pri_sch_ctrl_mem_ack  in  8  per-bank ack
pri_sch_ctrl_mem_rdata0..7  in  PIO_NBITS each  per-bank read data

Behaviour:
- Reset: state=IDLE; all outputs 0, including host_rdata, reg_addr and reg_din. Reset mid-access drops the strobes and select immediately and issues no host_ack.
- Decode:
  - bank = host_addr[DEPTH_NBITS+4:DEPTH_NBITS+2].
  - hit = host_addr[PIO_NBITS-1:DEPTH_NBITS+5] == BASE_ADDR[same bits].
  - host_addr[1:0] is ignored.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: host_req=1 with hit latches addr, wdata, wr and bank, then goes to ACCESS. host_req=1 with a miss goes to RESP with err=1 and touches no bus signal.
  - ACCESS: reg_addr, reg_din, reg_rd/reg_wr (per wr) and reg_ms_pri_sch_ctrl[bank] are all registered and held constant for the whole state. This covers banks running on clk_div.
    - When pri_sch_ctrl_mem_ack[bank]=1, capture mem_rdata[bank] (reads only; writes return 0), clear strobes and select, go to RESP with err=0.
    - Acks from unselected banks are ignored.
    - The timeout counter is cleared on entry and increments every ACCESS cycle. When it reaches TIMEOUT, clear strobes and select, set host_rdata=32'hDEAD_BEEF and err=1, go to RESP.
    - If ack and timeout coincide, the ack wins.
  - RESP: host_ack=1 and host_err valid for one cycle, then IDLE. host_rdata holds its value until the next completion.
- host_busy = (state != IDLE).
- Latency: host_req at cycle 0 puts strobes out at cycle 1. A selected ack at cycle N gives host_ack at N+1. Strobes are low at N+1, which guarantees at least one deasserted cycle between accesses.
- A host_req arriving in the same cycle as host_ack is ignored; the host must wait for host_busy=0.
- reg_rd and reg_wr are never both high. reg_ms_pri_sch_ctrl is 0 or one-hot.

Decomposition:
- Shared package (tm_pkg): state enum {IDLE, ACCESS, RESP}, NUM_PRI_BANKS=8, TIMEOUT_RDATA=32'hDEAD_BEEF.
- Bank-field/hit extraction and the 8:1 rdata mux stay inline.
- One natural sub-module: tm_pio_timeout_cnt (clear, enable, expire at TIMEOUT), reusable by other TM PIO initiators.

Test Plan:
- Write host_addr=0x0001_0304, wdata=0x0000_1234, bank 3 acks 4 cycles after strobe → reg_ms=8'h08, reg_wr=1 held 4 cycles; host_ack=1, err=0, reg_ms=0 the following cycle.
- Read 0x0001_0710 (bank 7, entry 4), bank 7 returns 0x0000_0A5C with ack → host_rdata=0x0000_0A5C, err=0, latency ack+1.
- Miss host_addr=0x0002_0000 → no reg_rd/reg_wr/reg_ms activity; host_ack 1 cycle after req with err=1.
- Read bank 2 never acks, with bank 5 ack pulsing → ignored; at cycle TIMEOUT=255 strobes drop, host_ack=1, err=1, rdata=0xDEAD_BEEF.
- Back-to-back host_req pulses while busy → only the first is executed; the next accepted req after host_busy=0 completes normally.
- rstn asserted mid-ACCESS → all outputs 0 asynchronously, no host_ack; the post-reset read completes correctly.
